// File: rtl/prefetch_pkg.sv
// Shared definitions for the stream prefetcher.
//   state_e       : FSM state encoding, also exported on outState
//   MODE_*        : channel stream kind (direct strided / two-level indirect)
//   SRC_*         : first-level read port selection
package prefetch_pkg;

  // state    | meaning
  // IDLE     | waiting for trigger, config writes accepted
  // ARB      | round-robin pick of next channel with work left
  // REQ1     | first-level read request held until accepted
  // WAIT1    | waiting for first-level data
  // REQ2     | indirect target read request (always cache)
  // WAIT2    | waiting for target data
  // WRITE    | one-cycle prefetch write pulse, element index advances
  // DONE     | one-cycle completion pulse
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ARB   = 4'd1,
    ST_REQ1  = 4'd2,
    ST_WAIT1 = 4'd3,
    ST_REQ2  = 4'd4,
    ST_WAIT2 = 4'd5,
    ST_WRITE = 4'd6,
    ST_DONE  = 4'd7
  } state_e;

  localparam logic MODE_DIRECT   = 1'b0;
  localparam logic MODE_INDIRECT = 1'b1;
  localparam logic SRC_CACHE     = 1'b0;
  localparam logic SRC_STRBUF    = 1'b1;

endpackage

// File: rtl/prefetch_rr_arbiter.sv
// Round-robin channel picker.
//   req_i   : one bit per channel that still has elements to fetch
//   last_i  : most recently granted channel; search starts just after it
//   gnt_o   : selected channel index (valid only with valid_o)
//   valid_o : at least one channel requested
module prefetch_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_i,
  output logic [CH_W-1:0]   gnt_o,
  output logic              valid_o
);

  logic [CH_W-1:0] cand;

  // Walk the channels starting at last_i+1, wrapping; k == NUM_CH revisits last_i
  // itself so a single busy channel keeps being granted.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last_i) + k) % NUM_CH);
      if (!valid_o && req_i[cand]) begin
        gnt_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_prefetcher.sv
// Multi-channel prefetch engine.
// Channels are programmed while idle through the cfg_* port as direct strided streams
// or two-level indirect streams (index read, then target read from cache). After a
// trigger pulse the channels are served round-robin, one outstanding read at a time,
// and every fetched word is emitted as a single w_valid_o pulse with its address.
//   clk, reset             : clock, synchronous active-high reset
//   trigger, cfg_*         : start pulse and per-channel configuration (idle only)
//   cache_* / wait_cache   : cache read port (req/addr out, stall/ready/data in)
//   strBuf_* / wait_strBuf : store-buffer read port
//   w_valid_o/w_addr_o/w_data_o : prefetch write output
//   done_o, outState       : completion pulse and current FSM state
module stream_prefetcher
  import prefetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_en,
  input  logic              cfg_mode,
  input  logic              cfg_src,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [ADDR_W-1:0] cfg_ind_base,
  input  logic [1:0]        cfg_shift,
  output logic              cache_data_req_o,
  output logic [ADDR_W-1:0] cache_r_addr_o,
  input  logic              wait_cache,
  input  logic              cache_data_ready,
  input  logic [DATA_W-1:0] cache_data_i,
  output logic              strBuf_data_req_o,
  output logic [ADDR_W-1:0] strBuf_r_addr_o,
  input  logic              wait_strBuf,
  input  logic              strBuf_data_ready,
  input  logic [DATA_W-1:0] strBuf_data_i,
  output logic              w_valid_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [DATA_W-1:0] w_data_o,
  output logic              done_o,
  output logic [3:0]        outState
);

  state_e state_q, state_d;

  logic              en_q       [NUM_CH];
  logic              mode_q     [NUM_CH];
  logic              src_q      [NUM_CH];
  logic [ADDR_W-1:0] base_q     [NUM_CH];
  logic [ADDR_W-1:0] stride_q   [NUM_CH];
  logic [CNT_W-1:0]  count_q    [NUM_CH];
  logic [ADDR_W-1:0] ind_base_q [NUM_CH];
  logic [1:0]        shift_q    [NUM_CH];
  logic [CNT_W-1:0]  idx_q      [NUM_CH];

  logic [CH_W-1:0]   cur_q, cur_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;

  logic [NUM_CH-1:0] ch_pending;
  logic [CH_W-1:0]   gnt;
  logic              gnt_valid;
  logic [ADDR_W-1:0] elem_addr;
  logic [ADDR_W-1:0] target_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_ready;
  logic              cfg_wr, clr_idx, inc_idx;
  logic              cache_req, sb_req;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_pending[c] = en_q[c] && (idx_q[c] < count_q[c]);
    end
  end

  prefetch_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req_i   (ch_pending),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .valid_o (gnt_valid)
  );

  // Element address is formed once at grant time and held in addr_q, which keeps
  // the request address stable for however long the port stalls.
  assign elem_addr   = base_q[gnt] + ADDR_W'(idx_q[gnt]) * stride_q[gnt];
  assign sel_data    = (src_q[cur_q] == SRC_STRBUF) ? strBuf_data_i : cache_data_i;
  assign sel_ready   = (src_q[cur_q] == SRC_STRBUF) ? strBuf_data_ready : cache_data_ready;
  assign target_addr = ind_base_q[cur_q] + (ADDR_W'(sel_data) << shift_q[cur_q]);
  assign cfg_wr      = cfg_we && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    addr_d    = addr_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    clr_idx   = 1'b0;
    inc_idx   = 1'b0;
    cache_req = 1'b0;
    sb_req    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          clr_idx = 1'b1;
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        if (gnt_valid) begin
          cur_d   = gnt;
          last_d  = gnt;
          addr_d  = elem_addr;
          state_d = ST_REQ1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_REQ1: begin
        if (src_q[cur_q] == SRC_STRBUF) begin
          sb_req = 1'b1;
          if (!wait_strBuf) state_d = ST_WAIT1;
        end else begin
          cache_req = 1'b1;
          if (!wait_cache) state_d = ST_WAIT1;
        end
      end
      ST_WAIT1: begin
        if (sel_ready) begin
          if (mode_q[cur_q] == MODE_INDIRECT) begin
            addr_d  = target_addr;
            state_d = ST_REQ2;
          end else begin
            w_addr_d = addr_q;
            w_data_d = sel_data;
            state_d  = ST_WRITE;
          end
        end
      end
      ST_REQ2: begin
        cache_req = 1'b1;
        if (!wait_cache) state_d = ST_WAIT2;
      end
      ST_WAIT2: begin
        if (cache_data_ready) begin
          w_addr_d = addr_q;
          w_data_d = cache_data_i;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        inc_idx = 1'b1;
        state_d = ST_ARB;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      last_q   <= CH_W'(NUM_CH - 1);  // so channel 0 is searched first
      addr_q   <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        en_q[c]       <= 1'b0;
        mode_q[c]     <= 1'b0;
        src_q[c]      <= 1'b0;
        base_q[c]     <= '0;
        stride_q[c]   <= '0;
        count_q[c]    <= '0;
        ind_base_q[c] <= '0;
        shift_q[c]    <= '0;
        idx_q[c]      <= '0;
      end
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_wr && (cfg_ch == CH_W'(c))) begin
          en_q[c]       <= cfg_en;
          mode_q[c]     <= cfg_mode;
          src_q[c]      <= cfg_src;
          base_q[c]     <= cfg_base;
          stride_q[c]   <= cfg_stride;
          count_q[c]    <= cfg_count;
          ind_base_q[c] <= cfg_ind_base;
          shift_q[c]    <= cfg_shift;
        end
        if (clr_idx) begin
          idx_q[c] <= '0;
        end else if (inc_idx && (cur_q == CH_W'(c))) begin
          idx_q[c] <= idx_q[c] + CNT_W'(1);
        end
      end
    end
  end

  assign cache_data_req_o  = cache_req;
  assign strBuf_data_req_o = sb_req;
  assign cache_r_addr_o    = addr_q;
  assign strBuf_r_addr_o   = addr_q;
  assign w_valid_o         = (state_q == ST_WRITE);
  assign w_addr_o          = w_addr_q;
  assign w_data_o          = w_data_q;
  assign done_o            = (state_q == ST_DONE);
  assign outState          = state_q;

endmodule

// File: tb/tb_stream_prefetcher.sv
module tb_stream_prefetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic        cfg_en = 1'b0, cfg_mode = 1'b0, cfg_src = 1'b0;
  logic [31:0] cfg_base = '0, cfg_stride = '0, cfg_ind_base = '0;
  logic [15:0] cfg_count = '0;
  logic [1:0]  cfg_shift = '0;
  logic        cache_data_req_o;
  logic [31:0] cache_r_addr_o;
  logic        wait_cache = 1'b0, cache_data_ready = 1'b0;
  logic [31:0] cache_data_i = '0;
  logic        strBuf_data_req_o;
  logic [31:0] strBuf_r_addr_o;
  logic        wait_strBuf = 1'b0, strBuf_data_ready = 1'b0;
  logic [31:0] strBuf_data_i = '0;
  logic        w_valid_o;
  logic [31:0] w_addr_o, w_data_o;
  logic        done_o;
  logic [3:0]  outState;

  int checks = 0;
  int errors = 0;

  stream_prefetcher dut (
    .clk(clk), .reset(reset), .trigger(trigger),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_src(cfg_src),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_count(cfg_count),
    .cfg_ind_base(cfg_ind_base), .cfg_shift(cfg_shift),
    .cache_data_req_o(cache_data_req_o), .cache_r_addr_o(cache_r_addr_o), .wait_cache(wait_cache),
    .cache_data_ready(cache_data_ready), .cache_data_i(cache_data_i),
    .strBuf_data_req_o(strBuf_data_req_o), .strBuf_r_addr_o(strBuf_r_addr_o), .wait_strBuf(wait_strBuf),
    .strBuf_data_ready(strBuf_data_ready), .strBuf_data_i(strBuf_data_i),
    .w_valid_o(w_valid_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .done_o(done_o), .outState(outState)
  );

  always #5 clk = ~clk;

  // Memory model: cache returns addr + 0x1000_0000, store buffer returns sb_data.
  logic [31:0] cache_log[$], sb_log[$], wa_log[$], wd_log[$];
  int          req_hi_cnt = 0, addr_chg_cnt = 0, both_cnt = 0;
  int          c_lat = 2;
  int          stall_idx = -1, stall_cycles = 0;
  logic [31:0] sb_data = '0;

  initial begin : responder
    int c_cnt, s_cnt, c_wait;
    logic [31:0] c_addr, prev_addr;
    logic prev_req;
    c_cnt = 0; s_cnt = 0; c_wait = 0; c_addr = '0; prev_addr = '0; prev_req = 1'b0;
    forever begin
      @(negedge clk);
      cache_data_ready  = 1'b0;
      strBuf_data_ready = 1'b0;
      if (w_valid_o) begin
        wa_log.push_back(w_addr_o);
        wd_log.push_back(w_data_o);
      end
      if (cache_data_req_o && strBuf_data_req_o) both_cnt++;
      if (cache_data_req_o) begin
        req_hi_cnt++;
        if (prev_req && prev_addr != cache_r_addr_o) addr_chg_cnt++;
      end
      prev_req  = cache_data_req_o;
      prev_addr = cache_r_addr_o;
      if (c_cnt > 0) begin
        c_cnt--;
        if (c_cnt == 0) begin
          cache_data_ready = 1'b1;
          cache_data_i     = c_addr + 32'h1000_0000;
        end
      end
      if (s_cnt > 0) begin
        s_cnt--;
        if (s_cnt == 0) begin
          strBuf_data_ready = 1'b1;
          strBuf_data_i     = sb_data;
        end
      end
      wait_cache = 1'b0;
      if (cache_data_req_o) begin
        if (cache_log.size() == stall_idx && c_wait < stall_cycles) begin
          wait_cache = 1'b1;
          c_wait++;
        end else begin
          c_addr = cache_r_addr_o;
          c_cnt  = c_lat;
          c_wait = 0;
          cache_log.push_back(cache_r_addr_o);
        end
      end
      if (strBuf_data_req_o) begin
        s_cnt = 2;
        sb_log.push_back(strBuf_r_addr_o);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic en, input logic mode, input logic src,
                     input logic [31:0] base, input logic [31:0] stride, input logic [15:0] cnt,
                     input logic [31:0] ibase, input logic [1:0] sh);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch; cfg_en = en; cfg_mode = mode; cfg_src = src;
    cfg_base = base; cfg_stride = stride; cfg_count = cnt; cfg_ind_base = ibase; cfg_shift = sh;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_trigger();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    int n;
    n = 0;
    while (!done_o && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL %s done_o timeout: got %b after %0d cycles, need 1", name, done_o, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (outState !== 4'd0) begin errors++; $display("FAIL reset outState: got %0d need 0", outState); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset done_o: got %b need 0", done_o); end
    checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL reset w_valid_o: got %b need 0", w_valid_o); end
    checks++; if (cache_data_req_o !== 1'b0) begin errors++; $display("FAIL reset cache_req: got %b need 0", cache_data_req_o); end
    checks++; if (strBuf_data_req_o !== 1'b0) begin errors++; $display("FAIL reset strBuf_req: got %b need 0", strBuf_data_req_o); end
    checks++; if (cache_r_addr_o !== 32'h0) begin errors++; $display("FAIL reset cache_addr: got %h need 0", cache_r_addr_o); end
    checks++; if (strBuf_r_addr_o !== 32'h0) begin errors++; $display("FAIL reset strBuf_addr: got %h need 0", strBuf_r_addr_o); end
    checks++; if (w_addr_o !== 32'h0) begin errors++; $display("FAIL reset w_addr_o: got %h need 0", w_addr_o); end
    checks++; if (w_data_o !== 32'h0) begin errors++; $display("FAIL reset w_data_o: got %h need 0", w_data_o); end
  endtask

  task automatic test_direct();
    logic [31:0] ea[3] = '{32'h100, 32'h104, 32'h108};
    logic [31:0] ed[3] = '{32'h1000_0100, 32'h1000_0104, 32'h1000_0108};
    int b;
    do_reset();
    c_lat = 2;
    cfg(2'd0, 1'b1, 1'b0, 1'b0, 32'h100, 32'd4, 16'd3, 32'h0, 2'd0);
    b = wa_log.size();
    pulse_trigger();
    wait_done(300, "direct");
    @(negedge clk);
    checks++; if (wa_log.size() - b != 3) begin errors++; $display("FAIL direct write count: got %0d need 3", wa_log.size() - b); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wa_log[b+i] !== ea[i]) begin errors++; $display("FAIL direct w_addr[%0d]: got %h need %h", i, wa_log[b+i], ea[i]); end
      checks++; if (wd_log[b+i] !== ed[i]) begin errors++; $display("FAIL direct w_data[%0d]: got %h need %h", i, wd_log[b+i], ed[i]); end
    end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL direct done pulse width: got %b need 0", done_o); end
    checks++; if (outState !== 4'd0) begin errors++; $display("FAIL direct back to idle: got %0d need 0", outState); end
    checks++; if (w_addr_o !== 32'h108) begin errors++; $display("FAIL direct w_addr hold: got %h need 108", w_addr_o); end
  endtask

  task automatic test_indirect();
    int bs, bc, bw, bb;
    do_reset();
    sb_data = 32'd5;
    cfg(2'd1, 1'b1, 1'b1, 1'b1, 32'h200, 32'd4, 16'd1, 32'h1000, 2'd2);
    bs = sb_log.size(); bc = cache_log.size(); bw = wa_log.size(); bb = both_cnt;
    pulse_trigger();
    wait_done(300, "indirect");
    @(negedge clk);
    checks++; if (sb_log.size() - bs != 1 || sb_log[bs] !== 32'h200) begin errors++; $display("FAIL indirect index req: got n=%0d addr %h need n=1 addr 200", sb_log.size() - bs, sb_log[bs]); end
    checks++; if (cache_log.size() - bc != 1 || cache_log[bc] !== 32'h1014) begin errors++; $display("FAIL indirect target req: got n=%0d addr %h need n=1 addr 1014", cache_log.size() - bc, cache_log[bc]); end
    checks++; if (wa_log.size() - bw != 1) begin errors++; $display("FAIL indirect write count: got %0d need 1", wa_log.size() - bw); end
    checks++; if (wa_log[bw] !== 32'h1014) begin errors++; $display("FAIL indirect w_addr: got %h need 1014", wa_log[bw]); end
    checks++; if (wd_log[bw] !== 32'h1000_1014) begin errors++; $display("FAIL indirect w_data: got %h need 10001014", wd_log[bw]); end
    checks++; if (both_cnt != bb) begin errors++; $display("FAIL indirect both reqs high: got %0d cycles need 0", both_cnt - bb); end
  endtask

  task automatic test_round_robin();
    logic [31:0] eo[4] = '{32'h100, 32'h300, 32'h104, 32'h304};
    int bc, bw;
    do_reset();
    cfg(2'd0, 1'b1, 1'b0, 1'b0, 32'h100, 32'd4, 16'd2, 32'h0, 2'd0);
    cfg(2'd1, 1'b0, 1'b0, 1'b0, 32'h200, 32'd4, 16'd2, 32'h0, 2'd0);
    cfg(2'd2, 1'b1, 1'b0, 1'b0, 32'h300, 32'd4, 16'd2, 32'h0, 2'd0);
    cfg(2'd3, 1'b0, 1'b0, 1'b0, 32'h400, 32'd4, 16'd2, 32'h0, 2'd0);
    bc = cache_log.size(); bw = wa_log.size();
    pulse_trigger();
    wait_done(400, "round_robin");
    @(negedge clk);
    checks++; if (cache_log.size() - bc != 4) begin errors++; $display("FAIL rr request count: got %0d need 4", cache_log.size() - bc); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cache_log[bc+i] !== eo[i]) begin errors++; $display("FAIL rr order[%0d]: got %h need %h", i, cache_log[bc+i], eo[i]); end
    end
    checks++; if (wa_log.size() - bw != 4) begin errors++; $display("FAIL rr write count: got %0d need 4", wa_log.size() - bw); end
  endtask

  task automatic test_stall();
    int bc, r0, a0;
    do_reset();
    cfg(2'd0, 1'b1, 1'b0, 1'b0, 32'h500, 32'd4, 16'd1, 32'h0, 2'd0);
    bc = cache_log.size(); r0 = req_hi_cnt; a0 = addr_chg_cnt;
    stall_idx = bc; stall_cycles = 5;
    pulse_trigger();
    wait_done(300, "stall");
    stall_cycles = 0; stall_idx = -1;
    @(negedge clk);
    checks++; if (req_hi_cnt - r0 != 6) begin errors++; $display("FAIL stall req cycles: got %0d need 6", req_hi_cnt - r0); end
    checks++; if (addr_chg_cnt != a0) begin errors++; $display("FAIL stall addr changes: got %0d need 0", addr_chg_cnt - a0); end
    checks++; if (cache_log.size() - bc != 1) begin errors++; $display("FAIL stall acceptances: got %0d need 1", cache_log.size() - bc); end
    checks++; if (w_addr_o !== 32'h500) begin errors++; $display("FAIL stall w_addr: got %h need 500", w_addr_o); end
  endtask

  task automatic check_fast_done(input string name);
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    checks++; if (outState !== 4'd1 || done_o !== 1'b0) begin errors++; $display("FAIL %s cycle1: got state %0d done %b need state 1 done 0", name, outState, done_o); end
    @(negedge clk);
    checks++; if (outState !== 4'd7 || done_o !== 1'b1) begin errors++; $display("FAIL %s cycle2: got state %0d done %b need state 7 done 1", name, outState, done_o); end
    @(negedge clk);
    checks++; if (outState !== 4'd0 || done_o !== 1'b0) begin errors++; $display("FAIL %s cycle3: got state %0d done %b need state 0 done 0", name, outState, done_o); end
  endtask

  task automatic test_edges();
    int bc, bw;
    do_reset();
    check_fast_done("no_channels");
    for (int c = 0; c < 4; c++) cfg(2'(c), 1'b1, 1'b0, 1'b0, 32'h700, 32'd4, 16'd0, 32'h0, 2'd0);
    check_fast_done("zero_counts");
    do_reset();
    cfg(2'd0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd8, 16'd2, 32'h0, 2'd0);
    bc = cache_log.size(); bw = wa_log.size();
    pulse_trigger();
    repeat (3) @(negedge clk);
    trigger = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_en = 1'b1; cfg_count = 16'd9; cfg_base = 32'h0;
    @(negedge clk);
    trigger = 1'b0; cfg_we = 1'b0;
    wait_done(300, "wrap");
    repeat (3) @(negedge clk);
    checks++; if (cache_log.size() - bc != 2) begin errors++; $display("FAIL wrap request count: got %0d need 2", cache_log.size() - bc); end
    checks++; if (cache_log[bc] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap addr0: got %h need fffffffc", cache_log[bc]); end
    checks++; if (cache_log[bc+1] !== 32'h4) begin errors++; $display("FAIL wrap addr1: got %h need 4", cache_log[bc+1]); end
    checks++; if (wa_log.size() - bw != 2) begin errors++; $display("FAIL busy cfg/trigger write count: got %0d need 2", wa_log.size() - bw); end
    checks++; if (outState !== 4'd0) begin errors++; $display("FAIL busy trigger restart: got state %0d need 0", outState); end
  endtask

  task automatic test_reset_mid();
    int bw, bc, n;
    do_reset();
    c_lat = 4;
    cfg(2'd0, 1'b1, 1'b1, 1'b0, 32'h600, 32'd4, 16'd1, 32'h2000, 2'd0);
    bw = wa_log.size(); bc = cache_log.size();
    pulse_trigger();
    n = 0;
    while (outState !== 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (outState !== 4'd5) begin errors++; $display("FAIL reset_mid reach WAIT2: got state %0d need 5", outState); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (outState !== 4'd0) begin errors++; $display("FAIL reset_mid state: got %0d need 0", outState); end
    checks++; if (cache_data_req_o !== 1'b0 || strBuf_data_req_o !== 1'b0) begin errors++; $display("FAIL reset_mid reqs: got %b%b need 00", cache_data_req_o, strBuf_data_req_o); end
    checks++; if (cache_r_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mid cache_addr: got %h need 0", cache_r_addr_o); end
    checks++; if (w_valid_o !== 1'b0 || w_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mid write out: got v=%b a=%h need v=0 a=0", w_valid_o, w_addr_o); end
    repeat (10) @(negedge clk);
    checks++; if (cache_log.size() - bc != 2 || cache_log[bc+1] !== 32'h1000_2600) begin errors++; $display("FAIL reset_mid target req: got n=%0d addr %h need n=2 addr 10002600", cache_log.size() - bc, cache_log[bc+1]); end
    checks++; if (wa_log.size() != bw) begin errors++; $display("FAIL reset_mid late ready wrote: got %0d writes need 0", wa_log.size() - bw); end
    checks++; if (outState !== 4'd0) begin errors++; $display("FAIL reset_mid stays idle: got %0d need 0", outState); end
    c_lat = 2;
  endtask

  initial begin : main
    test_reset();
    test_direct();
    test_indirect();
    test_round_robin();
    test_stall();
    test_edges();
    test_reset_mid();
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL exclusive reqs: got %0d overlapping cycles need 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
